fetch_sequencer: RTL

Program-counter and fetch controller that drives the CPU's combinational instruction memory and delivers one instruction per cycle to decode over a valid/ready interface. It owns the PC and handles sequential increment, backpressure from decode, and branch/jump redirects. It also handles halt, and traps fetches beyond the last populated memory word.

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: feeds a combinational instruction memory and hands one
// instruction per cycle to decode over valid/ready. Optional counters enabled by FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int                 WIDTH               = 32,
    parameter int                 INSTRACTION_NUMBERS = 1,
    parameter logic [WIDTH-1:0]   RESET_PC            = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt_req,
    output logic             halted,
    output logic             fault
`ifdef FETCH_PERF_EN
    ,
    output logic [WIDTH-1:0] perf_fetched,
    output logic [WIDTH-1:0] perf_stall
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    // One extra bit so a memory size of 2^WIDTH words still compares correctly.
    localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(INSTRACTION_NUMBERS);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;

    logic slot_free;
    logic drained;
    logic pc_in_range;
    logic fetch_go;

    assign slot_free   = !out_valid_q || out_ready;
    assign drained     = out_valid_q && out_ready;
    assign pc_in_range = ({1'b0, pc_q} < PC_LIMIT);

    // Priority: redirect, then halt, then fetch or fault; a plain drain otherwise.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fetch_go    = 1'b0;

        if (redirect_valid) begin
            out_valid_d = 1'b0;
            pc_d        = redirect_target;
            state_d     = ST_RUN;
        end else if (state_q == ST_RUN && halt_req) begin
            state_d = ST_HALTED;
            if (drained) begin
                out_valid_d = 1'b0;
            end
        end else if (state_q == ST_RUN && slot_free) begin
            if (pc_in_range) begin
                fetch_go    = 1'b1;
                out_instr_d = imem_data;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + 1'b1;
            end else begin
                state_d = ST_FAULT;
                if (drained) begin
                    out_valid_d = 1'b0;
                end
            end
        end else if (drained) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [WIDTH-1:0] perf_fetched_q;
    logic [WIDTH-1:0] perf_stall_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (fetch_go && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 1'b1;
            end
            if (out_valid_q && !out_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == ST_HALTED);
    assign fault     = (state_q == ST_FAULT);

endmodule
